mm_master: RTL and testbench
============================

// Module: mm_master
// PURPOSE
//  Avalon-MM initiator: turns single commands from a valid/ready command port
//  into one read or write transfer on an Avalon-MM bus, honouring waitrequest.
//  Returns read data and status on a valid/ready response port.
//  Sits between a control sequencer (or host bridge) and the mm register slave.
// PARAMETERS
//  AW       8   address width (bits)
//  DW       16  data width (bits)
//  TIMEOUT  255 max bus cycles per transfer; 0 = no timeout
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  cmd_valid        in   1   command present
//  cmd_ready        out  1   command accepted when cmd_valid && cmd_ready
//  cmd_write        in   1   1 = write, 0 = read
//  cmd_address      in   AW  transfer address
//  cmd_writedata    in   DW  write data (ignored for reads)
//  rsp_valid        out  1   response present
//  rsp_ready        in   1   response consumed when rsp_valid && rsp_ready
//  rsp_readdata     out  DW  read data; 0 for writes and errors
//  rsp_error        out  1   1 = transfer aborted by timeout
//  avm_address      out  AW  bus address
//  avm_read         out  1   bus read strobe
//  avm_write        out  1   bus write strobe
//  avm_writedata    out  DW  bus write data
//  avm_readdata     in   DW  bus read data, valid when avm_read && !avm_waitrequest
//  avm_waitrequest  in   1   slave stall
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - Reset values:
//    - all outputs 0; state IDLE.
//    - cmd_ready is 0 while rst is high and 1 in the first cycle after.
//  - States: IDLE -> BUS -> RESP -> IDLE; exactly one transfer in flight.
//  - IDLE:
//    - cmd_ready = 1.
//    - On accept at edge N: latch op/address/data.
//    - avm_read or avm_write is high from cycle N+1 (state BUS).
//  - BUS:
//    - cmd_ready = 0.
//    - avm_address, avm_writedata and the strobe are held stable.
//    - Exactly one strobe is high; read and write are never both high.
//    - Completion: rising edge with strobe && !avm_waitrequest.
//      - avm_readdata is sampled at that edge (reads only).
//      - The strobe drops the next cycle; go to RESP.
//  - Timeout (TIMEOUT > 0):
//    - Counter clears on entry to BUS and increments each BUS cycle.
//    - If waitrequest is still high in BUS cycle TIMEOUT: abort.
//      - Strobe drops the next cycle; go to RESP.
//      - rsp_error = 1, rsp_readdata = 0.
//    - Strobe is therefore high for at most TIMEOUT cycles.
//    - Counter width: $clog2(TIMEOUT+1). No wrap is possible.
//    - A completion in cycle TIMEOUT wins over the abort.
//  - RESP:
//    - rsp_valid = 1 with rsp_readdata/rsp_error stable until rsp_ready.
//    - Strobes stay low; cmd_ready = 0.
//    - Handshake at edge M: go to IDLE; cmd_ready = 1 at M+1.
//  - Minimum 3 cycles per command (accept, bus, response with rsp_ready = 1).
//  - rst mid-operation:
//    - Strobes and rsp_valid are 0 the next cycle.
//    - The pending transfer/response is discarded; state IDLE.
//  - Inputs are sampled only in their own state:
//    - waitrequest and readdata outside BUS have no effect.
//    - cmd_* outside IDLE have no effect.
// TESTING
//  1. rst high 4 cycles, then low
//     -> all avm_* = 0, rsp_valid = 0, cmd_ready = 0 during reset; cmd_ready = 1 on the next cycle.
//  2. Read addr 0x01, waitrequest = 0, slave returns the address
//     -> avm_read high 1 cycle; rsp_readdata = 0x0001, rsp_error = 0.
//  3. Write addr 0x02 data 0xBEEF, waitrequest high 3 cycles
//     -> avm_write high 4 cycles, address/data stable; response error = 0, readdata = 0.
//  4. Reads 0x02, 0x03, 0x03 back-to-back, rsp_ready low 2 cycles each
//     -> response held stable; no new strobe until consumed; readdata = 0x0002, 0x0003, 0x0003.
//  5. TIMEOUT = 16, waitrequest stuck high on a read
//     -> avm_read high exactly 16 cycles; rsp_error = 1, rsp_readdata = 0; next command proceeds normally.
//  6. rst pulsed in the 2nd BUS cycle
//     -> strobe 0 next cycle; no rsp_valid; cmd_ready = 1 in the first cycle after rst is released.

Source files
------------

// File: rtl/mm_master_if.sv
// Command, response and Avalon-MM bus signals of the mm_master initiator.
// master = the initiator's view; slave = the view of the sequencer and bus slave around it.
interface mm_master_if #(
    parameter int AW = 8,
    parameter int DW = 16
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_writedata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_readdata;
    logic          rsp_error;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        input  rsp_ready,
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        output rsp_ready,
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mm_master.sv
// Avalon-MM initiator: one command -> one bus transfer -> one response; >=3 cycles per command.
// Backpressure: waitrequest stretches the strobe (bounded by TIMEOUT); rsp_ready low holds the response.
module mm_master #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mm_master_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q,   err_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // cnt_q counts completed BUS cycles, so it equals CNT_LAST during BUS cycle TIMEOUT.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_BUS;
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_address;
                    wdata_d = bus.cmd_writedata;
                    cnt_d   = '0;
                end
            end
            S_BUS: begin
                if (!bus.avm_waitrequest) begin
                    state_d = S_RESP;
                    rdata_d = write_q ? '0 : bus.avm_readdata;
                    err_d   = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // cmd_ready is gated by rst so it reads 0 for the whole reset window.
    assign bus.cmd_ready     = (state_q == S_IDLE) && !rst;
    assign bus.avm_read      = (state_q == S_BUS) && !write_q;
    assign bus.avm_write     = (state_q == S_BUS) &&  write_q;
    assign bus.avm_address   = addr_q;
    assign bus.avm_writedata = wdata_q;
    assign bus.rsp_valid     = (state_q == S_RESP);
    assign bus.rsp_readdata  = rdata_q;
    assign bus.rsp_error     = err_q;
endmodule

// File: tb/tb_mm_master.sv
// Randomized and directed bench for mm_master with a transaction-level reference model.
module tb_mm_master;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_master_if #(.AW(8), .DW(16)) bus ();

    mm_master #(.AW(8), .DW(16), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: read data is {rd_hi, address}; waitrequest is high for the first stall_n strobe cycles.
    logic [7:0] rd_hi = 8'h00;
    assign bus.avm_readdata = {rd_hi, bus.avm_address};

    int dir_stall = 0;
    int stall_n   = 0;
    int scyc      = 0;
    int last_len  = 0;
    int picks[8]  = '{0, 1, 2, 3, 15, 16, 17, 40};

    always @(posedge clk) begin
        #1;
        if (bus.avm_read || bus.avm_write) begin
            scyc++;
            if (scyc == 1)
                stall_n = (dir_stall >= 0) ? dir_stall : picks[$urandom_range(0, 7)];
            bus.avm_waitrequest = (scyc <= stall_n);
        end else begin
            if (scyc > 0) last_len = scyc;
            scyc = 0;
            bus.avm_waitrequest = 1'($urandom_range(0, 1));
        end
        if (dir_stall < 0) rd_hi = 8'($urandom);
    end

    // Reference model: one outstanding transaction, tracked by what has happened to it so far.
    bit          m_act  = 0;
    bit          m_done = 0;
    bit          m_w    = 0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    logic [15:0] m_rd   = '0;
    bit          m_err  = 0;
    int          m_len  = 0;
    bit          rst_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
            if (rst_prev) begin
                chk("rst_ctl", 32'({bus.avm_read, bus.avm_write, bus.rsp_valid, bus.rsp_error, bus.avm_address}), 32'(0));
                chk("rst_dat", {bus.avm_writedata, bus.rsp_readdata}, 32'(0));
            end
            m_act    = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_act));
            chk("avm_read",  32'(bus.avm_read),  32'(m_act && !m_done && !m_w));
            chk("avm_write", 32'(bus.avm_write), 32'(m_act && !m_done &&  m_w));
            if (m_act && !m_done) begin
                chk("avm_address",   32'(bus.avm_address),   32'(m_addr));
                chk("avm_writedata", 32'(bus.avm_writedata), 32'(m_data));
            end
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_act && m_done));
            if (m_act && m_done) begin
                chk("rsp_readdata", 32'(bus.rsp_readdata), 32'(m_rd));
                chk("rsp_error",    32'(bus.rsp_error),    32'(m_err));
            end
            if (!m_act) begin
                if (bus.cmd_valid) begin
                    m_act  = 1;
                    m_done = 0;
                    m_len  = 0;
                    m_w    = bus.cmd_write;
                    m_addr = bus.cmd_address;
                    m_data = bus.cmd_writedata;
                end
            end else if (!m_done) begin
                m_len++;
                if (!bus.avm_waitrequest) begin
                    m_done = 1;
                    m_rd   = m_w ? 16'h0 : bus.avm_readdata;
                    m_err  = 0;
                end else if (m_len == TO) begin
                    m_done = 1;
                    m_rd   = 16'h0;
                    m_err  = 1;
                end
            end else if (bus.rsp_ready) begin
                m_act = 0;
            end
        end
    end

    task automatic send(input bit w, input logic [7:0] a, input logic [15:0] d);
        bit acc;
        int n = 0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = w;
        bus.cmd_address   = a;
        bus.cmd_writedata = d;
        forever begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("cmd_accept_timeout", 32'(n), 32'(0));
                break;
            end
        end
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'($urandom_range(0, 1));
        bus.cmd_address   = 8'($urandom);
        bus.cmd_writedata = 16'($urandom);
    endtask

    task automatic get_rsp(input int hold, output logic [15:0] d, output logic e);
        int n = 0;
        d = 16'hxxxx;
        e = 1'bx;
        bus.rsp_ready = (hold == 0);
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            n++;
            if (n > 200) begin
                chk("rsp_timeout", 32'(n), 32'(0));
                bus.rsp_ready = 1'b0;
                return;
            end
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        d = bus.rsp_readdata;
        e = bus.rsp_error;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;
    logic [7:0]  t4_addr[3] = '{8'h02, 8'h03, 8'h03};
    logic [15:0] t4_exp[3]  = '{16'h0002, 16'h0003, 16'h0003};

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_address   = '0;
        bus.cmd_writedata = '0;
        bus.rsp_ready     = 1'b0;

        // Reset for four edges, then cmd_ready must rise in the first cycle after.
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_ready_after_rst", 32'(bus.cmd_ready), 32'(1));
        @(posedge clk);
        #1;

        dir_stall = 0;
        send(1'b0, 8'h01, 16'h0000);
        get_rsp(0, rd, er);
        chk("t2_rdata", 32'(rd), 32'h0001);
        chk("t2_err",   32'(er), 32'(0));
        chk("t2_len",   32'(last_len), 32'(1));

        dir_stall = 3;
        send(1'b1, 8'h02, 16'hBEEF);
        get_rsp(0, rd, er);
        chk("t3_rdata", 32'(rd), 32'h0000);
        chk("t3_err",   32'(er), 32'(0));
        chk("t3_len",   32'(last_len), 32'(4));

        dir_stall = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, t4_addr[i], 16'h1234);
            get_rsp(2, rd, er);
            chk("t4_rdata", 32'(rd), 32'(t4_exp[i]));
            chk("t4_err",   32'(er), 32'(0));
        end

        dir_stall = 100;
        send(1'b0, 8'h05, 16'h0000);
        get_rsp(1, rd, er);
        chk("t5_rdata", 32'(rd), 32'h0000);
        chk("t5_err",   32'(er), 32'(1));
        chk("t5_len",   32'(last_len), 32'(TO));

        // Completion in the last allowed cycle beats the abort.
        dir_stall = TO - 1;
        send(1'b0, 8'h06, 16'h0000);
        get_rsp(0, rd, er);
        chk("t5b_rdata", 32'(rd), 32'h0006);
        chk("t5b_err",   32'(er), 32'(0));
        chk("t5b_len",   32'(last_len), 32'(TO));

        dir_stall = 0;
        send(1'b0, 8'h07, 16'h0000);
        get_rsp(0, rd, er);
        chk("t5c_rdata", 32'(rd), 32'h0007);
        chk("t5c_err",   32'(er), 32'(0));

        // Reset during the second BUS cycle discards the transfer.
        dir_stall = 10;
        send(1'b0, 8'h09, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_ready",  32'(bus.cmd_ready), 32'(1));
        chk("t6_strobe", 32'({bus.avm_read, bus.avm_write}), 32'(0));
        chk("t6_rsp",    32'(bus.rsp_valid), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        dir_stall = 0;
        send(1'b0, 8'h0A, 16'h0000);
        get_rsp(0, rd, er);
        chk("t6_next_rdata", 32'(rd), 32'h000A);

        dir_stall = -1;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    send(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
            end
            begin
                logic [15:0] rr;
                logic        ee;
                for (int j = 0; j < 80; j++)
                    get_rsp($urandom_range(0, 3), rr, ee);
            end
        join

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
